touch_adc_ctrl: RTL and testbench

- Serial master for the 4-wire resistive touch ADC (ADS7843-style, 24-DCLK frames).
- Generates the ADC DCLK, chip select and command stream, and drives the enable and clear inputs of the downstream 12-bit shift-in stage.
- Latches that stage's parallel result as an X then Y coordinate, then presents the pair with a one-cycle valid strobe to the display/cursor logic.

---
 rtl/touch_adc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_touch_adc_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_ctrl.sv
// Serial master for an ADS7843-style 4-wire touch ADC: runs an X then a Y 24-DCLK
// frame, drives the external shift-in stage and strobes the coordinate pair.
// Optional pen-down gating is compiled in with `define TOUCH_PENIRQ_EN.
module touch_adc_ctrl #(
  parameter int          CLK_DIV    = 4,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90,
  parameter int          GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
`ifdef TOUCH_PENIRQ_EN
  input  logic        pen_irq_n,
`endif
  output logic        touch_clk,
  output logic        touch_cs_n,
  output logic        touch_din,
  output logic        shift_ena,
  output logic        shift_rst,
  input  logic [11:0] shift_data,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        valid,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FRAME = 3'd2,
    S_LATCH = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]    PH_LAST   = 6'd47;
  // Enable window opens on the fall ending period 9, closes on the fall ending period 21.
  localparam logic [5:0]    ENA_FIRST = 6'd18;
  localparam logic [5:0]    ENA_LAST  = 6'd41;

  state_t         state, state_d;
  logic           sel, sel_d;
  logic [HW-1:0]  half;
  logic [5:0]     phase;
  logic [GW-1:0]  gap_cnt;
  logic           half_done, frame_done, gap_done;
  logic           pen_ok, pen_up;
  logic [7:0]     cmd;
  logic [4:0]     bit_idx;

`ifdef TOUCH_PENIRQ_EN
  logic [1:0] pen_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pen_sync <= 2'b11;
    else      pen_sync <= {pen_sync[0], pen_irq_n};
  end

  assign pen_ok = ~pen_sync[1];
  assign pen_up = pen_sync[1];
`else
  assign pen_ok = 1'b1;
  assign pen_up = 1'b0;
`endif

  assign half_done  = (half == HALF_LAST);
  assign frame_done = (state == S_FRAME) && (phase == PH_LAST) && half_done;
  assign gap_done   = (state == S_GAP) && (gap_cnt == GAP_LAST);
  assign cmd        = sel ? CMD_Y : CMD_X;
  assign bit_idx    = phase[5:1];

  // phase is held at zero outside FRAME, so its LSB is a clean registered DCLK.
  assign touch_clk  = phase[0];
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      sel     <= 1'b0;
      half    <= '0;
      phase   <= '0;
      gap_cnt <= '0;
      x_pos   <= '0;
      y_pos   <= '0;
      valid   <= 1'b0;
    end else begin
      state <= state_d;
      sel   <= sel_d;

      if (state == S_FRAME) begin
        if (half_done) begin
          half  <= '0;
          phase <= frame_done ? 6'd0 : phase + 6'd1;
        end else begin
          half  <= half + HW'(1);
        end
      end else begin
        half  <= '0;
        phase <= '0;
      end

      if ((state == S_GAP) && !gap_done) gap_cnt <= gap_cnt + GW'(1);
      else                               gap_cnt <= '0;

      // Capture on the edge into LATCH so the new pair and valid appear together.
      valid <= 1'b0;
      if (frame_done) begin
        if (sel) begin
          y_pos <= shift_data;
          valid <= 1'b1;
        end else begin
          x_pos <= shift_data;
        end
      end
    end
  end

  always_comb begin
    state_d    = state;
    sel_d      = sel;
    touch_cs_n = 1'b1;
    touch_din  = 1'b0;
    shift_ena  = 1'b0;
    shift_rst  = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start && pen_ok) begin
          state_d = S_CLEAR;
          sel_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        touch_cs_n = 1'b0;
        touch_din  = cmd[7];
        state_d    = S_FRAME;
      end
      S_FRAME: begin
        touch_cs_n = 1'b0;
        shift_rst  = 1'b1;
        if (bit_idx < 5'd8) touch_din = cmd[3'd7 - bit_idx[2:0]];
        shift_ena  = (phase >= ENA_FIRST) && (phase <= ENA_LAST);
        if (frame_done) state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_rst = 1'b1;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_done) begin
          if (pen_up) begin
            state_d = S_IDLE;
          end else if (!sel) begin
            state_d = S_CLEAR;
            sel_d   = 1'b1;
          end else if (continuous) begin
            state_d = S_CLEAR;
            sel_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Directed bench for touch_adc_ctrl: models the ADC and the 12-bit shift-in stage,
// monitors DCLK/command/enable framing and scoreboards each coordinate pair.
module tb_touch_adc_ctrl;

  typedef struct {
    logic [11:0] adc_x;
    logic [11:0] adc_y;
    logic [11:0] exp_x;
    logic [11:0] exp_y;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
`ifdef TOUCH_PENIRQ_EN
  logic        pen_irq_n = 1'b0;
`endif
  logic        touch_clk, touch_cs_n, touch_din, shift_ena, shift_rst;
  logic [11:0] shift_data, x_pos, y_pos;
  logic        valid, busy;
  logic [2:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;
  logic [23:0] exp_q[$];
  vec_t vecs[4];

  touch_adc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
`ifdef TOUCH_PENIRQ_EN
    .pen_irq_n  (pen_irq_n),
`endif
    .touch_clk  (touch_clk),
    .touch_cs_n (touch_cs_n),
    .touch_din  (touch_din),
    .shift_ena  (shift_ena),
    .shift_rst  (shift_rst),
    .shift_data (shift_data),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .valid      (valid),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ADC + shift-in stage model ----------------
  logic [11:0] adc_x = '0, adc_y = '0, shift_reg = '0, adc_val;
  logic [7:0]  cmd_cap = '0;
  int          adc_cnt = 0;

  function automatic logic adc_bit(input int c, input logic [11:0] v);
    if (c >= 9 && c <= 20) return v[20 - c];
    return 1'b0;
  endfunction

  assign adc_val    = (cmd_cap == 8'hD0) ? adc_x : (cmd_cap == 8'h90) ? adc_y : 12'h000;
  assign shift_data = shift_reg;

  always @(posedge touch_clk or posedge touch_cs_n)
    if (touch_cs_n) adc_cnt <= 0;
    else            adc_cnt <= adc_cnt + 1;

  always @(posedge touch_clk or negedge shift_rst)
    if (!shift_rst)     shift_reg <= '0;
    else if (shift_ena) shift_reg <= {shift_reg[10:0], adc_bit(adc_cnt, adc_val)};

  // ---------------- frame monitor ----------------
  logic prev_tclk = 1'b0, prev_cs_n = 1'b1, prev_din = 1'b0, tclk_rise;
  int rise_cnt = 0, ena_cnt = 0, din_bad = 0, ena_bad = 0;
  int cs_low_cnt = 0, tclk_hi_cnt = 0, busy_cnt = 0, srst_cnt = 0, valid_cnt = 0;
  int fr_cmd_q[$], fr_rise_q[$], fr_ena_q[$];

  assign tclk_rise = touch_clk & ~prev_tclk;

  always @(negedge clk) begin
    prev_tclk <= touch_clk;
    prev_cs_n <= touch_cs_n;
    prev_din  <= touch_din;
    if (!touch_cs_n) cs_low_cnt  <= cs_low_cnt + 1;
    if (touch_clk)   tclk_hi_cnt <= tclk_hi_cnt + 1;
    if (busy)        busy_cnt    <= busy_cnt + 1;
    if (shift_rst)   srst_cnt    <= srst_cnt + 1;
    if (valid)       valid_cnt   <= valid_cnt + 1;
    if (!prev_cs_n && touch_cs_n) begin
      fr_cmd_q.push_back(int'(cmd_cap));
      fr_rise_q.push_back(rise_cnt);
      fr_ena_q.push_back(ena_cnt);
    end
    if (touch_cs_n) begin
      rise_cnt <= 0;
      ena_cnt  <= 0;
      cmd_cap  <= '0;
    end else if (tclk_rise) begin
      rise_cnt <= rise_cnt + 1;
      if (rise_cnt < 8) cmd_cap <= {cmd_cap[6:0], touch_din};
      if (shift_ena) begin
        ena_cnt <= ena_cnt + 1;
        if (rise_cnt < 9 || rise_cnt > 20) ena_bad <= ena_bad + 1;
      end
    end
    if (!touch_cs_n && !prev_cs_n && (touch_din !== prev_din) && !(prev_tclk && !touch_clk))
      din_bad <= din_bad + 1;
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int vcyc, output bit ok);
    ok = 1'b0;
    vcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [11:0] ex, input logic [11:0] ey,
                           input int t0, input int exp_lat, output int vcyc);
    bit ok;
    logic [23:0] e;
    exp_q.push_back({ex, ey});
    wait_valid(600, vcyc, ok);
    chk({tag, "_valid_seen"}, 32'(ok), 32'd1);
    e = exp_q.pop_front();
    if (ok) begin
      chk({tag, "_latency"}, 32'(vcyc - t0), 32'(exp_lat));
      chk({tag, "_x_pos"}, 32'(x_pos), 32'(e[23:12]));
      chk({tag, "_y_pos"}, 32'(y_pos), 32'(e[11:0]));
    end
  endtask

  task automatic check_frames(input string tag, input int base, input int n);
    int got;
    got = fr_cmd_q.size() - base;
    chk({tag, "_frame_count"}, 32'(got), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < fr_cmd_q.size()) begin
        chk({tag, "_frame_cmd"}, 32'(fr_cmd_q[base + i]), (i % 2 == 0) ? 32'hD0 : 32'h90);
        chk({tag, "_frame_rises"}, 32'(fr_rise_q[base + i]), 32'd24);
        chk({tag, "_frame_ena_rises"}, 32'(fr_ena_q[base + i]), 32'd12);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, t1, v1, v2, v3, base, s_cs, s_tclk, s_busy, s_srst, s_valid;
    bit ok, found;

    // Pair latency: 2 * (1 + 48*4 + 1) + 16 = 404; continuous Y-to-Y spacing adds a
    // second gap: 2 * 194 + 2 * 16 = 420.
    vecs[0] = '{12'hA5C, 12'h3F1, 12'hA5C, 12'h3F1, 404};
    vecs[1] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 404};
    vecs[2] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 404};
    vecs[3] = '{12'h801, 12'h7FE, 12'h801, 12'h7FE, 404};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_touch_clk", 32'(touch_clk), 32'd0);
    chk("rst_cs_n", 32'(touch_cs_n), 32'd1);
    chk("rst_din", 32'(touch_din), 32'd0);
    chk("rst_shift_ena", 32'(shift_ena), 32'd0);
    chk("rst_shift_rst", 32'(shift_rst), 32'd0);
    chk("rst_x_pos", 32'(x_pos), 32'd0);
    chk("rst_y_pos", 32'(y_pos), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // idle after release with no start
    rst = 1'b1;
    @(negedge clk);
    s_cs = cs_low_cnt; s_tclk = tclk_hi_cnt; s_busy = busy_cnt; s_srst = srst_cnt; s_valid = valid_cnt;
    repeat (200) @(negedge clk);
    chk("idle_cs_low_cycles", 32'(cs_low_cnt - s_cs), 32'd0);
    chk("idle_tclk_high_cycles", 32'(tclk_hi_cnt - s_tclk), 32'd0);
    chk("idle_busy_cycles", 32'(busy_cnt - s_busy), 32'd0);
    chk("idle_shift_rst_cycles", 32'(srst_cnt - s_srst), 32'd0);
    chk("idle_valid_pulses", 32'(valid_cnt - s_valid), 32'd0);

    // single pairs from the vector table
    for (int i = 0; i < 4; i++) begin
      base = fr_cmd_q.size();
      s_valid = valid_cnt;
      adc_x = vecs[i].adc_x;
      adc_y = vecs[i].adc_y;
      pulse_start(t0);
      run_check($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y, t0, vecs[i].exp_lat, v1);
      wait_idle($sformatf("vec%0d", i));
      check_frames($sformatf("vec%0d", i), base, 2);
      chk($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - s_valid), 32'd1);
    end

    // start spam while busy, then a start on the first IDLE cycle
    base = fr_cmd_q.size();
    adc_x = 12'h1C3; adc_y = 12'hE2A;
    pulse_start(t0);
    for (int k = 0; k < 10; k++) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    run_check("spam", 12'h1C3, 12'hE2A, t0, 404, v1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("spam_idle_reached", 32'(found), 32'd1);
    start = 1'b1;
    t1 = cyc;
    chk("spam_frames_before_restart", 32'(fr_cmd_q.size() - base), 32'd2);
    @(negedge clk);
    start = 1'b0;
    adc_x = 12'h2B4; adc_y = 12'h4D6;
    run_check("restart", 12'h2B4, 12'h4D6, t1, 404, v1);
    wait_idle("restart");
    check_frames("restart", base, 4);

    // continuous mode, dropped during the third pair
    base = fr_cmd_q.size();
    continuous = 1'b1;
    adc_x = 12'h111; adc_y = 12'h222;
    pulse_start(t0);
    run_check("cont1", 12'h111, 12'h222, t0, 404, v1);
    adc_x = 12'h333; adc_y = 12'h444;
    run_check("cont2", 12'h333, 12'h444, v1, 420, v2);
    adc_x = 12'h555; adc_y = 12'h666;
    repeat (100) @(negedge clk);
    continuous = 1'b0;
    run_check("cont3", 12'h555, 12'h666, v2, 420, v3);
    wait_idle("cont");
    check_frames("cont", base, 6);
    wait_valid(500, v1, ok);
    chk("cont_no_extra_valid", 32'(ok), 32'd0);
    chk("cont_busy_after", 32'(busy), 32'd0);

    // reset during DCLK period 15 of the Y frame
    base = fr_cmd_q.size();
    adc_x = 12'h123; adc_y = 12'h456;
    pulse_start(t0);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if ((fr_cmd_q.size() - base == 1) && !touch_cs_n && rise_cnt == 15) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_reached_y_period15", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_touch_clk", 32'(touch_clk), 32'd0);
    chk("midrst_cs_n", 32'(touch_cs_n), 32'd1);
    chk("midrst_din", 32'(touch_din), 32'd0);
    chk("midrst_shift_ena", 32'(shift_ena), 32'd0);
    chk("midrst_shift_rst", 32'(shift_rst), 32'd0);
    chk("midrst_x_pos", 32'(x_pos), 32'd0);
    chk("midrst_y_pos", 32'(y_pos), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    base = fr_cmd_q.size();
    adc_x = 12'h9AB; adc_y = 12'hCDE;
    pulse_start(t0);
    run_check("postrst", 12'h9AB, 12'hCDE, t0, 404, v1);
    wait_idle("postrst");
    check_frames("postrst", base, 2);

`ifdef TOUCH_PENIRQ_EN
    // pen up blocks start; pen release mid-pair aborts it
    pen_irq_n = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start(t0);
    repeat (50) @(negedge clk);
    chk("pen_up_stays_idle", 32'(busy), 32'd0);
    pen_irq_n = 1'b0;
    repeat (4) @(negedge clk);
    adc_x = 12'h0F0; adc_y = 12'h70E;
    pulse_start(t0);
    repeat (100) @(negedge clk);
    pen_irq_n = 1'b1;
    wait_valid(600, v1, ok);
    chk("pen_release_no_valid", 32'(ok), 32'd0);
    chk("pen_release_idle", 32'(busy), 32'd0);
    chk("pen_release_y_kept", 32'(y_pos), 32'h0CDE);
    pen_irq_n = 1'b0;
`endif

    chk("din_changes_off_falling_edge", 32'(din_bad), 32'd0);
    chk("shift_ena_outside_window", 32'(ena_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
